data_sram_responder: RTL and testbench

- Responder (slave) end of the data-side SRAM-like request interface driven by the pipeline's memory stage (`mem_en`, `mem_wen`, `mem_addr`, `mem_wdata`, `data_size` in; `mem_rdata` out).
- Backs the interface with an on-chip word array and a programmable wait-state counter.
- Stalls the pipeline until each access completes.
- Used for on-chip data scratchpad and as the bench model for memory-stage bring-up.

---
 rtl/data_sram_responder.sv | 189 ++++++++++++++++++
 tb/tb_data_sram_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder
// Responder end of the data-side SRAM-like request interface. A request seen
// in IDLE is latched, held in BUSY for WAIT_CYCLES extra cycles, performed on
// the last BUSY cycle, and reported in DONE with a one-cycle data_ok pulse.
// The requester is stalled from the cycle it raises mem_en until DONE.
//
// Optional feature: define DATA_SRAM_RESP_PERF_CNT_EN to build the completed
// read/write counters on rd_cnt/wr_cnt. Left undefined, both ports are tied
// to zero and no counter registers exist.
module data_sram_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  data_size,
    output logic [31:0] mem_rdata,
    output logic        stall,
    output logic        data_ok,
    output logic        bus_error,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam int unsigned TAG_W     = 30 - ADDR_WIDTH;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    // Upper word-address bits every in-range access must carry.
    localparam logic [TAG_W-1:0] BASE_TAG = BASE_ADDR[31:ADDR_WIDTH+2];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    // Copy of the request taken on acceptance; the live bus is ignored after
    // that, so a requester that changes fields mid-stall cannot corrupt it.
    typedef struct packed {
        logic [29:0] word_addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic [2:0]  size;
    } req_t;

    state_t                  state;
    state_t                  state_nxt;
    req_t                    req_q;
    logic [3:0]              wait_cnt;
    logic                    accept;
    logic                    access_now;
    logic                    acc_err;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [31:0]             mem [DEPTH];

    // Byte offset bits are not used: alignment is the requester's job.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^mem_addr[1:0];

    // Access decode on the latched request.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        accept     = 1'b0;
        access_now = 1'b0;
        acc_err    = 1'b0;
        acc_idx    = req_q.word_addr[ADDR_WIDTH-1:0];
        if (state == ST_IDLE && mem_en) begin
            accept = 1'b1;
        end
        if (state == ST_BUSY && wait_cnt == 4'd0) begin
            access_now = 1'b1;
        end
        if (req_q.word_addr[29:ADDR_WIDTH] != BASE_TAG || req_q.size > 3'd2) begin
            acc_err = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values regardless of block ordering.
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and the combinational stall.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = mem_en;
                if (mem_en) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (wait_cnt == 4'd0) begin
                    state_nxt = ST_DONE;
                end
            end
            // The completing request's mem_en is still high here; going to
            // IDLE unconditionally keeps it from being taken a second time.
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch and wait-state counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q    <= '0;
            wait_cnt <= 4'd0;
        end else if (accept) begin
            req_q    <= '{word_addr: mem_addr[31:2], wen: mem_wen,
                          wdata: mem_wdata, size: data_size};
            wait_cnt <= WAIT_INIT;
        end else if (state == ST_BUSY && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Response registers: loaded on the access cycle, presented in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rdata <= 32'd0;
            data_ok   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            data_ok   <= access_now;
            bus_error <= access_now && acc_err;
            if (access_now) begin
                // Reads the pre-write word: the array update below lands on
                // the same edge, so the requester sees the old contents.
                mem_rdata <= acc_err ? 32'd0 : mem[acc_idx];
            end
        end
    end

    // Byte-lane array write on a successful access.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; a reset mid-access is still safe because state is forced to IDLE, so access_now cannot fire.
        if (access_now && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (req_q.wen[i]) begin
                    mem[acc_idx][8*i +: 8] <= req_q.wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef DATA_SRAM_RESP_PERF_CNT_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    // Completed-access counters, bumped in DONE on error-free accesses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else if (data_ok && !bus_error) begin
            if (req_q.wen == 4'd0) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end else begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`else
    assign rd_cnt = 32'd0;
    assign wr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder
// Directed and randomized accesses against a word-array reference model.
// The driver pushes the model's expected response into a scoreboard queue;
// an independent monitor pops and compares on every data_ok.
module tb_data_sram_responder;

    localparam int unsigned AW    = 6;
    localparam int unsigned WORDS = 1 << AW;
    localparam logic [31:0] BASE  = 32'h0000_4000;
    localparam int unsigned WAITS = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_en = 1'b0;
    logic [3:0]  mem_wen = 4'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [2:0]  data_size = 3'd0;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        data_ok;
    logic        bus_error;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    data_sram_responder #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(WAITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_en   (mem_en),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .data_size(data_size),
        .mem_rdata(mem_rdata),
        .stall    (stall),
        .data_ok  (data_ok),
        .bus_error(bus_error),
        .rd_cnt   (rd_cnt),
        .wr_cnt   (wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk_rd;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_mem [WORDS];
    bit          model_known [WORDS];
    int          exp_rd = 0;
    int          exp_wr = 0;
    logic [31:0] last_rdata = 32'd0;
    bit          last_known = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && data_ok) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_data_ok: got data_ok=1 expected no completion at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("bus_error", {31'd0, bus_error}, {31'd0, e.err});
                if (e.chk_rd) begin
                    check("mem_rdata", mem_rdata, e.rdata);
                end
            end
        end
    end

    // Reference: an access is in range if its byte offset from BASE falls in
    // the array; a legal size is byte/half/word. Read returns the old word.
    function automatic exp_t model_access(input logic [3:0] wen, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [2:0] size);
        exp_t        e;
        logic [31:0] off;
        int          idx;
        off = addr - BASE;
        idx = int'(off >> 2) % WORDS;
        if (off >= 32'(4 * WORDS) || size > 3'd2) begin
            e.rdata  = 32'd0;
            e.err    = 1'b1;
            e.chk_rd = 1'b1;
        end else begin
            e.rdata  = model_mem[idx];
            e.err    = 1'b0;
            e.chk_rd = model_known[idx];
            for (int b = 0; b < 4; b++) begin
                if (wen[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
            if (wen == 4'hF) model_known[idx] = 1'b1;
            if (wen == 4'd0) exp_rd++;
            else exp_wr++;
        end
        return e;
    endfunction

    // Called at a negedge with the DUT in IDLE. Returns at the negedge of the
    // following IDLE cycle with mem_en still high from the finished request.
    task automatic access(input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] size);
        exp_t e;
        int   cyc;
        bit   done;
        e = model_access(wen, addr, wdata, size);
        sb_q.push_back(e);
        mem_en    = 1'b1;
        mem_wen   = wen;
        mem_addr  = addr;
        mem_wdata = wdata;
        data_size = size;
        #1;
        check("stall_idle_req", {31'd0, stall}, 32'd1);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (data_ok) done = 1'b1;
            else check("stall_busy", {31'd0, stall}, 32'd1);
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: got no data_ok after %0d cycles expected %0d", cyc, WAITS + 2);
        end else begin
            check("latency", 32'(cyc), 32'(WAITS + 2));
            check("stall_done", {31'd0, stall}, 32'd0);
        end
        last_rdata = e.rdata;
        last_known = e.chk_rd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        mem_en = 1'b0;
        repeat (n) @(negedge clk);
        if (last_known) check("rdata_hold", mem_rdata, last_rdata);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        logic [3:0]  we;
        exp_t        dummy;

        for (int i = 0; i < WORDS; i++) model_known[i] = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_data_ok", {31'd0, data_ok}, 32'd0);
        check("rst_bus_error", {31'd0, bus_error}, 32'd0);
        check("rst_rd_cnt", rd_cnt, 32'd0);
        check("rst_wr_cnt", wr_cnt, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Give every word a known value.
        for (int i = 0; i < WORDS; i++) begin
            access(4'hF, BASE + 32'(i * 4), $urandom, 3'd2);
        end
        idle(2);

        // Full write then read back.
        access(4'hF, BASE + 32'h10, 32'h1122_3344, 3'd2);
        access(4'h0, BASE + 32'h10, 32'h0, 3'd2);
        idle(1);
        // Byte-lane write; its own rdata is the old word.
        access(4'b0100, BASE + 32'h10, 32'hAAAA_AAAA, 3'd0);
        access(4'h0, BASE + 32'h10, 32'h0, 3'd2);
        idle(3);
        // Out-of-range read and illegal-size write.
        access(4'h0, BASE + (32'd4 << AW), 32'h0, 3'd2);
        access(4'hF, BASE + 32'h10, 32'h5555_5555, 3'd5);
        access(4'h0, BASE + 32'h10, 32'h0, 3'd2);
        idle(1);

        // Reset in the middle of a write: the write must not land.
        mem_en    = 1'b1;
        mem_wen   = 4'hF;
        mem_addr  = BASE + 32'h10;
        mem_wdata = 32'hFFFF_FFFF;
        data_size = 3'd2;
        @(negedge clk);
        rst    = 1'b0;
        mem_en = 1'b0;
        #1;
        check("abort_rdata", mem_rdata, 32'd0);
        check("abort_data_ok", {31'd0, data_ok}, 32'd0);
        check("abort_bus_error", {31'd0, bus_error}, 32'd0);
        check("abort_stall", {31'd0, stall}, 32'd0);
        check("abort_rd_cnt", rd_cnt, 32'd0);
        exp_rd     = 0;
        exp_wr     = 0;
        last_rdata = 32'd0;
        last_known = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        access(4'h0, BASE + 32'h10, 32'h0, 3'd2);
        idle(1);

        // Randomized traffic, mixing back-to-back and idle-separated requests.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = BASE + (32'($urandom_range(0, WORDS - 1)) << 2) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) sz = 3'($urandom_range(3, 7));
            else sz = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) we = 4'd0;
            else we = 4'($urandom_range(1, 15));
            access(we, a, $urandom, sz);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(4);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
`ifdef DATA_SRAM_RESP_PERF_CNT_EN
        check("rd_cnt", rd_cnt, 32'(exp_rd));
        check("wr_cnt", wr_cnt, 32'(exp_wr));
`else
        check("rd_cnt_tied", rd_cnt, 32'd0);
        check("wr_cnt_tied", wr_cnt, 32'd0);
`endif
        dummy = '{rdata: 32'd0, err: 1'b0, chk_rd: 1'b0};
        if (dummy.chk_rd) $display("unreachable");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1, "time limit");
    end

endmodule
